// File: rtl/ppu_pkg.sv
// ppu_pkg: shared types and constants for the PPU write queue
package ppu_pkg;
  localparam logic [3:0] COMMIT_NIBBLE = 4'hF;
  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wq_entry_t;
  typedef enum logic [0:0] {WQ_IDLE, WQ_DRAIN} wq_state_t;
endpackage

// File: rtl/ppu_wq_ram.sv
// ppu_wq_ram: simple dual-port queue storage, registered read, storage not reset
module ppu_wq_ram
  import ppu_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int W     = $bits(wq_entry_t),
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;
  assign o_rdata = r_rdata;
  // write port and one-cycle-latency read port
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/ppu_write_queue.sv
// ppu_write_queue: buffers host table writes and replays committed ones to the PPU during vblank
module ppu_write_queue
  import ppu_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int VACTIVE = 480
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_chipselect,
  input  logic                     i_write,
  input  logic [ADDR_W-1:0]        i_address,
  input  logic [DATA_W-1:0]        i_writedata,
  output logic                     o_waitrequest,
  input  logic [9:0]               i_vcount,
  output logic                     o_ppu_chipselect,
  output logic                     o_ppu_write,
  output logic [ADDR_W-1:0]        o_ppu_address,
  output logic [DATA_W-1:0]        o_ppu_writedata,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_draining
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = ADDR_W + DATA_W;
  // pointers carry one extra wrap bit so a full committed queue is distinct from an empty commit
  logic [AW:0]   r_wr_ptr, r_rd_ptr, r_commit_ptr, r_drain_end, r_level;
  logic          r_commit_pending, r_vblank_q, r_rd_valid;
  wq_state_t     r_state, w_state_nxt;
  logic          w_commit, w_push, w_pop, w_vb_rise, w_start, w_done;
  logic [EW-1:0] w_rd_data;
  assign w_commit      = i_chipselect & i_write & (i_address[ADDR_W-1 -: 4] == COMMIT_NIBBLE);
  assign o_waitrequest = r_level == (AW+1)'(DEPTH);
  assign w_push        = i_chipselect & i_write & !w_commit & !o_waitrequest;
  assign w_vb_rise     = (i_vcount >= 10'(VACTIVE)) & !r_vblank_q;
  assign o_level       = r_level;
  assign o_draining    = r_state == WQ_DRAIN;
  ppu_wq_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata ({i_address, i_writedata}),
    .i_re    (w_pop),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rd_data)
  );
  // drain starts on a vblank rising edge with a commit pending, ends once the last read has left the RAM
  always_comb begin
    w_pop       = (r_state == WQ_DRAIN) && (r_rd_ptr != r_drain_end);
    w_start     = (r_state == WQ_IDLE) & w_vb_rise & r_commit_pending;
    w_done      = (r_state == WQ_DRAIN) & !w_pop & !r_rd_valid;
    w_state_nxt = w_start ? WQ_DRAIN : w_done ? WQ_IDLE : r_state;
  end
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= WQ_IDLE;
    else r_state <= w_state_nxt;
  end
  // queue pointers, occupancy and commit bookkeeping; a commit in the start cycle stays pending
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_commit_ptr     <= '0;
      r_drain_end      <= '0;
      r_level          <= '0;
      r_commit_pending <= 1'b0;
      r_vblank_q       <= 1'b0;
      r_rd_valid       <= 1'b0;
    end else begin
      r_vblank_q       <= i_vcount >= 10'(VACTIVE);
      r_wr_ptr         <= w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
      r_rd_ptr         <= w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
      r_level          <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_commit_ptr     <= w_commit ? r_wr_ptr : r_commit_ptr;
      r_drain_end      <= w_start ? r_commit_ptr : r_drain_end;
      r_commit_pending <= w_commit | (r_commit_pending & !w_start);
      r_rd_valid       <= w_pop;
    end
  end
  // registered PPU bus: strobe for one cycle per read, address/data hold between strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_ppu_chipselect <= 1'b0;
      o_ppu_write      <= 1'b0;
      o_ppu_address    <= '0;
      o_ppu_writedata  <= '0;
    end else begin
      o_ppu_chipselect <= r_rd_valid;
      o_ppu_write      <= r_rd_valid;
      if (r_rd_valid) {o_ppu_address, o_ppu_writedata} <= w_rd_data;
    end
  end
endmodule
